// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit for the execute stage.
// Handles MUL, DIV, DIVU, REM, REMU and their W (32-bit) variants. Multiply
// is radix-2 shift-add and divide is restoring, one bit per cycle. One op is
// in flight at a time; the op can be aborted by flush_i or reset.
//
// Ports:
//   clk       clock
//   reset     synchronous active-high reset
//   valid_i   start request; f3_i/word_i/a_i/b_i valid this cycle
//   ready_o   unit idle and able to accept
//   flush_i   abort the in-flight op; also blocks an accept in idle
//   f3_i      funct3: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   word_i    W variant: 32-bit op with sign-extended result
//   a_i, b_i  rs1 / rs2 operands
//   done_o    one-cycle pulse; result_o valid this cycle
//   result_o  result, held from done until the next op completes or reset
module muldiv_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic [2:0]      f3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned HALF = XLEN / 2;
  localparam int unsigned CW   = $clog2(XLEN) + 1;

  localparam logic [XLEN-1:0] MinFull = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [HALF-1:0] MinHalf = {1'b1, {(HALF-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [XLEN-1:0] sext_half(input logic [XLEN-1:0] x);
    return {{HALF{x[HALF-1]}}, x[HALF-1:0]};
  endfunction

  state_e          r_state;
  state_e          w_state_nx;
  logic [2:0]      r_f3;
  logic            r_word;
  logic [CW-1:0]   r_cnt;
  // MUL: r_acc = partial product, r_opa = shifted multiplicand, r_opb = multiplier.
  // DIV: r_acc = partial remainder, r_opa = dividend bits out / quotient bits in,
  //      r_opb = divisor magnitude.
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_opa;
  logic [XLEN-1:0] r_opb;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;

  // Accept-time decode
  logic            w_accept;
  logic            w_is_div;
  logic            w_unsup;
  logic            w_signed;
  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_raw;
  logic [XLEN-1:0] w_special_res;

  // Iteration datapath
  logic [XLEN-1:0] w_mul_acc;
  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_diff;
  logic            w_q_bit;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_run_raw;
  logic [XLEN-1:0] w_run_res;
  logic            w_last;

  always_comb begin
    w_accept = (r_state == StIdle) && valid_i && !flush_i;
    w_is_div = f3_i[2];
    w_unsup  = !f3_i[2] && (f3_i[1:0] != 2'b00);
    w_signed = !f3_i[0];

    if (word_i) begin
      w_a_ext = w_signed ? sext_half(a_i) : {{HALF{1'b0}}, a_i[HALF-1:0]};
      w_b_ext = w_signed ? sext_half(b_i) : {{HALF{1'b0}}, b_i[HALF-1:0]};
    end else begin
      w_a_ext = a_i;
      w_b_ext = b_i;
    end

    w_a_neg = w_is_div && w_signed && w_a_ext[XLEN-1];
    w_b_neg = w_is_div && w_signed && w_b_ext[XLEN-1];
    w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

    w_div_zero = w_is_div && (w_b_ext == '0);
    if (word_i) begin
      w_ovf = w_is_div && w_signed && (a_i[HALF-1:0] == MinHalf) && (b_i[HALF-1:0] == '1);
    end else begin
      w_ovf = w_is_div && w_signed && (a_i == MinFull) && (b_i == '1);
    end
    w_special = w_unsup || w_div_zero || w_ovf;

    // Raw 64-bit result for the no-iteration cases; W ops sign-extend bit 31.
    w_special_raw = '0;
    if (w_div_zero) begin
      w_special_raw = f3_i[1] ? a_i : '1;
    end else if (w_ovf) begin
      w_special_raw = f3_i[1] ? '0 : a_i;
    end
    w_special_res = word_i ? sext_half(w_special_raw) : w_special_raw;
  end

  always_comb begin
    w_mul_acc = r_acc + (r_opb[0] ? r_opa : '0);

    w_trial  = {r_acc, r_opa[XLEN-1]};
    w_diff   = w_trial - {1'b0, r_opb};
    w_q_bit  = !w_diff[XLEN];
    w_rem_nx = w_q_bit ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
    w_quo_nx = {r_opa[XLEN-2:0], w_q_bit};

    w_quo_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
    w_rem_fix = r_neg_r ? -w_rem_nx : w_rem_nx;

    if (r_f3[2]) begin
      w_run_raw = r_f3[1] ? w_rem_fix : w_quo_fix;
    end else begin
      w_run_raw = w_mul_acc;
    end
    w_run_res = r_word ? sext_half(w_run_raw) : w_run_raw;

    w_last = (r_cnt == CW'(1));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next state and outputs
  always_comb begin
    w_state_nx = r_state;
    ready_o    = 1'b0;
    done_o     = 1'b0;
    unique case (r_state)
      StIdle: begin
        ready_o = 1'b1;
        if (w_accept) begin
          w_state_nx = w_special ? StDone : StRun;
        end
      end
      StRun: begin
        if (flush_i) begin
          w_state_nx = StIdle;
        end else if (w_last) begin
          w_state_nx = StDone;
        end
      end
      StDone: begin
        done_o     = 1'b1;
        w_state_nx = StIdle;
      end
      default: w_state_nx = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_f3     <= '0;
      r_word   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_f3   <= f3_i;
      r_word <= word_i;
      r_cnt  <= word_i ? CW'(HALF) : CW'(XLEN);
      r_acc  <= '0;
      if (w_is_div) begin
        // W dividends sit in the upper half so the MSB is always shifted out first.
        r_opa   <= word_i ? {w_a_mag[HALF-1:0], {HALF{1'b0}}} : w_a_mag;
        r_opb   <= w_b_mag;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end else begin
        r_opa   <= a_i;
        r_opb   <= b_i;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end
      if (w_special) begin
        r_result <= w_special_res;
      end
    end else if ((r_state == StRun) && !flush_i) begin
      if (r_f3[2]) begin
        r_acc <= w_rem_nx;
        r_opa <= w_quo_nx;
      end else begin
        r_acc <= w_mul_acc;
        r_opa <= r_opa << 1;
        r_opb <= r_opb >> 1;
      end
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_result <= w_run_res;
      end
    end
  end

  assign result_o = r_result;

endmodule
